// File: rtl/fmap_stream_reader.sv
// ----------------------------------------------------------------------------
// fmap_stream_reader
//
// Source end of the pixel stream. On a start request it walks a feature map
// of IMG_W x IMG_H pixels held in a synchronous-read memory, starting at
// base_addr, and emits the pixels in raster order with a per-pixel valid.
// Read issue can be throttled with ce; the read-return path is never
// throttled, so every issued read produces exactly one output pixel two
// cycles later.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-low reset
//   ce         issue enable (low stalls read issue only)
//   start      one-cycle frame start request (accepted only when idle)
//   base_addr  frame base address, sampled with an accepted start
//   rd_en      memory read strobe (combinational from state and ce)
//   rd_addr    memory read address (registered)
//   rd_data    memory data, valid one cycle after rd_en
//   dout       pixel value, holds when dout_vld is low
//   dout_vld   pixel qualifier
//   dout_col   column of the current pixel
//   dout_row   row of the current pixel
//   dout_eol   last pixel of a row
//   dout_last  last pixel of the frame
//   busy       frame in progress
//   done       one-cycle frame-complete pulse (same cycle as dout_last)
// ----------------------------------------------------------------------------
module fmap_stream_reader #(
   parameter int WIDTH = 8,
   parameter int IMG_W = 28,
   parameter int IMG_H = 28,
   parameter int AW    = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ce,
   input  logic                     start,
   input  logic [AW-1:0]            base_addr,
   output logic                     rd_en,
   output logic [AW-1:0]            rd_addr,
   input  logic [WIDTH-1:0]         rd_data,
   output logic [WIDTH-1:0]         dout,
   output logic                     dout_vld,
   output logic [$clog2(IMG_W)-1:0] dout_col,
   output logic [$clog2(IMG_H)-1:0] dout_row,
   output logic                     dout_eol,
   output logic                     dout_last,
   output logic                     busy,
   output logic                     done
);

   localparam int NPIX  = IMG_W * IMG_H;
   localparam int CNT_W = $clog2(NPIX);
   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = $clog2(IMG_H);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NPIX - 1);
   localparam logic [COL_W-1:0] COL_MAX  = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(IMG_H - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   // The address space must be able to hold one whole frame.
   if (AW < CNT_W) begin : g_aw_check
      $error("fmap_stream_reader: AW too small for IMG_W*IMG_H");
   end

   logic [1:0]       state_r;
   logic [1:0]       state_nxt_s;
   logic             busy_r;
   logic [CNT_W-1:0] issue_cnt_r;
   logic [AW-1:0]    rd_addr_r;
   logic             vld_p1_r;     // read issued last cycle, data on rd_data now
   logic [WIDTH-1:0] dout_r;
   logic             dout_vld_r;
   logic [COL_W-1:0] col_r;
   logic [ROW_W-1:0] row_r;
   logic [COL_W-1:0] col_nxt_s;
   logic [ROW_W-1:0] row_nxt_s;
   logic             eol_r;
   logic             last_r;

   assign rd_en     = (state_r == ST_RUN) && ce;
   assign rd_addr   = rd_addr_r;
   assign dout      = dout_r;
   assign dout_vld  = dout_vld_r;
   assign dout_col  = col_r;
   assign dout_row  = row_r;
   assign dout_eol  = eol_r;
   assign dout_last = last_r;
   assign done      = last_r;
   assign busy      = busy_r;

   // Frame sequencing: idle -> issuing reads -> waiting for the last pixel.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) state_nxt_s = ST_RUN;
            else       state_nxt_s = ST_IDLE;
         end
         ST_RUN: begin
            if (ce && (issue_cnt_r == LAST_IDX)) state_nxt_s = ST_DRAIN;
            else                                 state_nxt_s = ST_RUN;
         end
         ST_DRAIN: begin
            // The final pixel is on the output this cycle, so the frame is over.
            if (last_r) state_nxt_s = ST_IDLE;
            else        state_nxt_s = ST_DRAIN;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State, busy flag and read-issue address/counter.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r     <= ST_IDLE;
         busy_r      <= 1'b0;
         issue_cnt_r <= {CNT_W{1'b0}};
         rd_addr_r   <= {AW{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         busy_r  <= (state_nxt_s != ST_IDLE);
         if ((state_r == ST_IDLE) && start) begin
            issue_cnt_r <= {CNT_W{1'b0}};
            rd_addr_r   <= base_addr;
         end else if (rd_en) begin
            // rd_addr tracks base + issue count; wraps naturally at 2^AW.
            issue_cnt_r <= issue_cnt_r + CNT_W'(1);
            rd_addr_r   <= rd_addr_r + AW'(1);
         end else begin
            issue_cnt_r <= issue_cnt_r;
            rd_addr_r   <= rd_addr_r;
         end
      end
   end

   // Position of the pixel shown next: advances once per emitted pixel.
   always_comb begin
      col_nxt_s = col_r;
      row_nxt_s = row_r;
      if (dout_vld_r) begin
         if (col_r == COL_MAX) begin
            col_nxt_s = {COL_W{1'b0}};
            if (row_r == ROW_MAX) row_nxt_s = {ROW_W{1'b0}};
            else                  row_nxt_s = row_r + ROW_W'(1);
         end else begin
            col_nxt_s = col_r + COL_W'(1);
            row_nxt_s = row_r;
         end
      end else begin
         col_nxt_s = col_r;
         row_nxt_s = row_r;
      end
   end

   // Return path: capture read data and flag row/frame ends. Not gated by ce.
   always_ff @(posedge clk) begin
      if (!rst) begin
         vld_p1_r   <= 1'b0;
         dout_vld_r <= 1'b0;
         dout_r     <= {WIDTH{1'b0}};
         col_r      <= {COL_W{1'b0}};
         row_r      <= {ROW_W{1'b0}};
         eol_r      <= 1'b0;
         last_r     <= 1'b0;
      end else begin
         vld_p1_r   <= rd_en;
         dout_vld_r <= vld_p1_r;
         if (vld_p1_r) dout_r <= rd_data;
         else          dout_r <= dout_r;
         col_r  <= col_nxt_s;
         row_r  <= row_nxt_s;
         eol_r  <= vld_p1_r && (col_nxt_s == COL_MAX);
         last_r <= vld_p1_r && (col_nxt_s == COL_MAX) && (row_nxt_s == ROW_MAX);
      end
   end

endmodule

// File: tb/tb_fmap_stream_reader.sv
// ----------------------------------------------------------------------------
// tb_fmap_stream_reader
//
// Drives fmap_stream_reader (4x3 frame, AW=10) against a random-content
// memory and compares every cycle with a behavioural model: a frame is a list
// of pixel indices k = 0..N-1 at address (base+k) mod 1024, each read shows up
// as an output exactly two cycles after it was issued, at column k%W and row
// k/W.
// ----------------------------------------------------------------------------
module tb_fmap_stream_reader;

   localparam int WIDTH = 8;
   localparam int IMG_W = 4;
   localparam int IMG_H = 3;
   localparam int AW    = 10;
   localparam int NPIX  = IMG_W * IMG_H;
   localparam int MSIZE = 1 << AW;

   logic             clk = 1'b0;
   logic             rst;
   logic             ce;
   logic             start;
   logic [AW-1:0]    base_addr;
   logic             rd_en;
   logic [AW-1:0]    rd_addr;
   logic [WIDTH-1:0] rd_data;
   logic [WIDTH-1:0] dout;
   logic             dout_vld;
   logic [1:0]       dout_col;
   logic [1:0]       dout_row;
   logic             dout_eol;
   logic             dout_last;
   logic             busy;
   logic             done;

   fmap_stream_reader #(
      .WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)
   ) dut (
      .clk(clk), .rst(rst), .ce(ce), .start(start), .base_addr(base_addr),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .dout(dout), .dout_vld(dout_vld), .dout_col(dout_col), .dout_row(dout_row),
      .dout_eol(dout_eol), .dout_last(dout_last), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Synchronous-read memory.
   logic [WIDTH-1:0] mem [0:MSIZE-1];
   always @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

   int n_checks = 0;
   int n_errors = 0;

   // Model state
   int               cyc;
   bit               chk_en;
   bit               m_busy;
   int               m_issued;
   int               m_base;
   logic [WIDTH-1:0] m_dout;
   int               pend_cyc[$];
   int               pend_k[$];
   int               pend_addr[$];
   int               vld_cnt;
   int               done_cnt;
   bit               done_seen;
   int               done_cyc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_busy   = 1'b0;
      m_issued = 0;
      m_dout   = '0;
      pend_cyc.delete();
      pend_k.delete();
      pend_addr.delete();
   endtask

   // One clock cycle: apply inputs, check outputs against the model, advance
   // the model across the coming edge.
   task automatic step(input logic ce_v, input logic start_v, input logic rst_v,
                       input logic [AW-1:0] base_v);
      bit exp_rd;
      bit exp_vld;
      bit busy_now;
      int k;
      int a;
      ce        = ce_v;
      start     = start_v;
      rst       = rst_v;
      base_addr = base_v;
      #2;
      busy_now  = m_busy;
      exp_rd    = m_busy && (m_issued < NPIX) && ce_v;
      exp_vld   = (pend_cyc.size() > 0) && (pend_cyc[0] == cyc - 2);
      done_seen = 1'b0;
      if (chk_en) begin
         chk("busy", busy, m_busy);
         chk("rd_en", rd_en, exp_rd);
         if (exp_rd) chk("rd_addr", rd_addr, (m_base + m_issued) % MSIZE);
         chk("dout_vld", dout_vld, exp_vld);
         if (exp_vld) begin
            k = pend_k.pop_front();
            a = pend_addr.pop_front();
            void'(pend_cyc.pop_front());
            m_dout = mem[a];
            chk("dout", dout, m_dout);
            chk("dout_col", dout_col, k % IMG_W);
            chk("dout_row", dout_row, k / IMG_W);
            chk("dout_eol", dout_eol, (k % IMG_W) == IMG_W - 1);
            chk("dout_last", dout_last, k == NPIX - 1);
            chk("done", done, k == NPIX - 1);
            vld_cnt++;
            if (k == NPIX - 1) begin
               done_cnt++;
               done_seen = 1'b1;
               done_cyc  = cyc;
            end
         end else begin
            chk("dout_hold", dout, m_dout);
            chk("eol_idle", dout_eol, 1'b0);
            chk("last_idle", dout_last, 1'b0);
            chk("done_idle", done, 1'b0);
         end
      end
      if (!rst_v) begin
         model_reset();
      end else begin
         if (exp_rd) begin
            pend_cyc.push_back(cyc);
            pend_k.push_back(m_issued);
            pend_addr.push_back((m_base + m_issued) % MSIZE);
            m_issued++;
         end
         if (done_seen) m_busy = 1'b0;
         if (start_v && !busy_now) begin
            m_busy   = 1'b1;
            m_base   = int'(base_v);
            m_issued = 0;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // ce_mode: 0 always on, 1 toggling 1,0,1,..., 2 random.
   // poke: random extra start pulses while the frame runs.
   // abort_after: assert reset the cycle after that many outputs (0 = never).
   task automatic run_frame(input logic [AW-1:0] b, input int ce_mode, input bit poke,
                            input int abort_after);
      bit fin;
      bit aborted;
      int ph;
      int st_cyc;
      logic c;
      logic s;
      logic r;
      vld_cnt  = 0;
      done_cnt = 0;
      fin      = 1'b0;
      aborted  = 1'b0;
      ph       = 0;
      st_cyc   = cyc;
      step(1'b1, 1'b1, 1'b1, b);
      for (int i = 0; i < 300 && !fin; i++) begin
         case (ce_mode)
            0:       c = 1'b1;
            1:       c = ((ph % 2) == 0);
            default: c = 1'($urandom_range(0, 1));
         endcase
         ph++;
         s = poke && ($urandom_range(0, 3) == 0);
         r = !((abort_after > 0) && (vld_cnt >= abort_after));
         if (!r) aborted = 1'b1;
         step(c, s, r, s ? AW'($urandom) : b);
         if (done_seen || aborted) fin = 1'b1;
      end
      if (aborted) begin
         chk("abort_no_done", done_cnt, 0);
         chk("abort_partial", vld_cnt < NPIX, 1'b1);
      end else begin
         chk("frame_finished", fin, 1'b1);
         chk("frame_vld_count", vld_cnt, NPIX);
         chk("frame_done_count", done_cnt, 1);
         if (ce_mode == 0) chk("done_latency", done_cyc - st_cyc, NPIX + 2);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, '0);
   endtask

   initial begin
      rst       = 1'b0;
      ce        = 1'b0;
      start     = 1'b0;
      base_addr = '0;
      cyc       = 0;
      chk_en    = 1'b0;
      vld_cnt   = 0;
      done_cnt  = 0;
      done_cyc  = 0;
      m_base    = 0;
      model_reset();
      for (int i = 0; i < MSIZE; i++) mem[i] = WIDTH'($urandom);
      @(posedge clk);
      #1;
      cyc++;
      chk_en = 1'b1;

      // Reset state, including ce/start activity during reset.
      step(1'b1, 1'b1, 1'b0, 10'd5);
      step(1'b1, 1'b0, 1'b0, 10'd5);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_dout_col", dout_col, 0);
      chk("rst_dout_row", dout_row, 0);
      chk("rst_dout", dout, 0);
      idle(2);

      run_frame(10'd0, 0, 1'b0, 0);              // full-rate frame, base 0
      idle(3);
      run_frame(AW'($urandom), 1, 1'b0, 0);      // ce toggling
      run_frame(10'd1020, 2, 1'b0, 0);           // address wrap, back-to-back
      run_frame(AW'($urandom), 2, 1'b1, 0);      // start ignored while busy
      idle(2);
      run_frame(AW'($urandom), 0, 1'b0, 5);      // reset mid-frame
      idle(6);
      chk("post_abort_done", done_cnt, 0);
      run_frame(10'd0, 2, 1'b0, 0);              // fresh frame after abort
      run_frame(AW'($urandom), 0, 1'b0, 0);      // start the cycle after done
      for (int f = 0; f < 5; f++) run_frame(AW'($urandom), 2, 1'b1, 0);
      idle(4);
      chk("no_pending_reads", pend_cyc.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fmap_stream_reader.md
FMAP_STREAM_READER -- requirements
Module: fmap_stream_reader

Purpose: source end of the pixel stream. Reads a feature map from a synchronous-read memory and drives a raster-order pixel stream with a per-pixel valid, suitable for direct connection to a delay-line / line-buffer input (din, input_vld).

Interface
REQ-001 Parameter WIDTH, default 8, pixel width in bits.
REQ-002 Parameter IMG_W, default 28, pixels per row.
REQ-003 Parameter IMG_H, default 28, rows per frame.
REQ-004 Parameter AW, default 10, memory address width; the block SHALL require AW >= ceil(log2(IMG_W*IMG_H)).
REQ-005 clk  input  1  clock; all logic on the rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 ce  input  1  issue enable; low stalls read issue.
REQ-008 start  input  1  one-cycle frame start request.
REQ-009 base_addr  input  AW  frame base address, sampled with start.
REQ-010 rd_en  output  1  memory read strobe.
REQ-011 rd_addr  output  AW  memory read address.
REQ-012 rd_data  input  WIDTH  memory data, valid exactly 1 cycle after rd_en.
REQ-013 dout  output  WIDTH  pixel value.
REQ-014 dout_vld  output  1  dout qualifier, one cycle per pixel.
REQ-015 dout_col  output  clog2(IMG_W)  column of current pixel.
REQ-016 dout_row  output  clog2(IMG_H)  row of current pixel.
REQ-017 dout_eol  output  1  high with dout_vld on the last pixel of each row.
REQ-018 dout_last  output  1  high with dout_vld on the final frame pixel.
REQ-019 busy  output  1  high while a frame is in progress.
REQ-020 done  output  1  one-cycle frame-complete pulse.

Function
REQ-021 FSM states: IDLE, RUN, DRAIN; busy SHALL be 1 in any state other than IDLE.
REQ-022 In IDLE, start=1 SHALL latch base_addr, clear the issue counter, and enter RUN on the next cycle; start SHALL be ignored in RUN and DRAIN.
REQ-023 In RUN with ce=1: rd_en=1 and rd_addr=base+issue count (modulo 2^AW); the issue count SHALL increment by 1.
REQ-024 In RUN with ce=0: rd_en=0, and the issue count and rd_addr SHALL hold.
REQ-025 When a read is issued for pixel IMG_W*IMG_H-1, the FSM SHALL move RUN->DRAIN at that edge.
REQ-026 rd_en SHALL be combinationally derived from state and ce only; rd_addr SHALL be registered.
REQ-027 The return path SHALL NOT be gated by ce: a read issued in cycle t SHALL produce dout=rd_data, dout_vld=1 in cycle t+2 (rd_data captured at the end of cycle t+1).
REQ-028 dout SHALL hold its last value when dout_vld=0.
REQ-029 Output row/column counters SHALL advance only on dout_vld: col wraps IMG_W-1->0 and increments row; row wraps IMG_H-1->0 after the last pixel.
REQ-030 dout_eol SHALL be 1 iff dout_vld=1 and dout_col=IMG_W-1; dout_last SHALL be 1 iff dout_vld=1, col=IMG_W-1 and row=IMG_H-1.
REQ-031 done SHALL equal dout_last; in the same cycle the FSM SHALL go DRAIN->IDLE, so busy is 0 on the following cycle.
REQ-032 A start asserted in the cycle after done SHALL be accepted; back-to-back frames SHALL have a gap of no more than 2 cycles between dout_last and the next frame's first dout_vld beyond the pipeline latency.
REQ-033 Exactly IMG_W*IMG_H reads and IMG_W*IMG_H dout_vld pulses SHALL occur per accepted start, in ascending address order, regardless of the ce pattern.

Reset
REQ-034 With rst=0 at an edge: state=IDLE; rd_addr, dout, dout_col, and dout_row = 0; dout_vld, dout_eol, dout_last, done, busy, and rd_en = 0.
REQ-035 Reset mid-frame SHALL abort the frame: in-flight read data SHALL be discarded, no dout_vld SHALL occur after reset, and done SHALL not be generated.

Verification
REQ-036 IMG_W=4, IMG_H=3, memory[a]=a, base=0, ce=1, start at cycle 0 -> rd_en cycles 1..12 with addr 0..11, dout_vld cycles 3..14 with dout 0..11, dout_eol on dout 3/7/11, done at cycle 14.
REQ-037 The same configuration with ce toggled 1,0,1,0... -> 12 reads and 12 outputs in order 0..11 with no duplicates; each dout_vld occurs exactly 2 cycles after its rd_en.
REQ-038 base_addr=1020, AW=10 -> rd_addr sequence 1020..1023, 0..7 (wrap), with dout_row/dout_col unaffected.
REQ-039 start pulsed again during RUN -> ignored; exactly 12 outputs and a single done.
REQ-040 rst=0 on the cycle after the 5th dout_vld -> no further dout_vld and no done; busy=0; a fresh start then produces a full 12-pixel frame from row 0, col 0.
REQ-041 start asserted the cycle after done -> the second frame completes with correct row/col and a second done pulse.
